// File: rtl/jt12_timer_ctrl.sv
// jt12_timer_ctrl: CPU register decode for the FM timer pair (regs 0x24-0x27), CSM key-on
// strobe from Timer A overflow, and status byte {busy, 5'b0, flag_B, flag_A}.
// Latency: config/level outputs update on the data-write edge; clr/csm pulses are high the
// following clk. Backpressure: none, writes are always accepted; busy is advisory only.
// Optional feature: define JT12_TIMER_BUSY_EN to build the busy counter driving dout[7].
module jt12_timer_ctrl #(
  parameter int BUSY_CYCLES = 32,
  parameter int BUSY_W      = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clk_en,
  input  logic       i_wr,
  input  logic       i_addr,
  input  logic [7:0] i_din,
  input  logic       i_flag_A,
  input  logic       i_flag_B,
  input  logic       i_overflow_A,
  output logic [9:0] o_value_A,
  output logic [7:0] o_value_B,
  output logic       o_load_A,
  output logic       o_load_B,
  output logic       o_clr_flag_A,
  output logic       o_clr_flag_B,
  output logic       o_enable_irq_A,
  output logic       o_enable_irq_B,
  output logic [1:0] o_ch3_mode,
  output logic       o_csm_keyon,
  output logic [7:0] o_dout
);

  localparam logic [7:0] REG_NA_HI = 8'h24;
  localparam logic [7:0] REG_NA_LO = 8'h25;
  localparam logic [7:0] REG_NB    = 8'h26;
  localparam logic [7:0] REG_CTRL  = 8'h27;

  logic       w_addr_wr;
  logic       w_data_wr;
  logic       w_ctrl_wr;
  logic       w_busy;

  logic [7:0] r_reg_sel;
  logic [9:0] r_value_A;
  logic [7:0] r_value_B;
  logic       r_load_A;
  logic       r_load_B;
  logic       r_enable_irq_A;
  logic       r_enable_irq_B;
  logic [1:0] r_ch3_mode;
  logic       r_clr_flag_A;
  logic       r_clr_flag_B;
  logic       r_csm_keyon;

  // A single wr strobe is either an address phase or a data phase, never both
  assign w_addr_wr = i_wr & ~i_addr;
  assign w_data_wr = i_wr &  i_addr;
  assign w_ctrl_wr = w_data_wr && (r_reg_sel == REG_CTRL);

  // Register select latch and stored timer configuration, not gated by clk_en
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_sel      <= 8'h00;
      r_value_A      <= 10'h000;
      r_value_B      <= 8'h00;
      r_load_A       <= 1'b0;
      r_load_B       <= 1'b0;
      r_enable_irq_A <= 1'b0;
      r_enable_irq_B <= 1'b0;
      r_ch3_mode     <= 2'b00;
    end else begin
      if (w_addr_wr) begin
        r_reg_sel <= i_din;
      end
      if (w_data_wr) begin
        case (r_reg_sel)
          REG_NA_HI: r_value_A[9:2] <= i_din;
          REG_NA_LO: r_value_A[1:0] <= i_din[1:0];
          REG_NB:    r_value_B      <= i_din;
          REG_CTRL: begin
            // bits 5:4 are the write-only flag-clear commands and are not stored
            r_ch3_mode     <= i_din[7:6];
            r_enable_irq_B <= i_din[3];
            r_enable_irq_A <= i_din[2];
            r_load_B       <= i_din[1];
            r_load_A       <= i_din[0];
          end
          default: ;
        endcase
      end
    end
  end

  // Flag-clear pulses: one clk wide, high the clk after the control write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clr_flag_A <= 1'b0;
      r_clr_flag_B <= 1'b0;
    end else begin
      r_clr_flag_A <= w_ctrl_wr & i_din[4];
      r_clr_flag_B <= w_ctrl_wr & i_din[5];
    end
  end

  // CSM key-on strobe; the pre-write ch3_mode decides when a mode change coincides
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csm_keyon <= 1'b0;
    end else begin
      r_csm_keyon <= i_clk_en & i_overflow_A & r_ch3_mode[1];
    end
  end

`ifdef JT12_TIMER_BUSY_EN
  logic [BUSY_W-1:0] r_busy_cnt;

  // Busy counter: any data write reloads it (reload beats a same-clk tick), clk_en drains it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy_cnt <= '0;
    end else if (w_data_wr) begin
      r_busy_cnt <= BUSY_W'(BUSY_CYCLES);
    end else if (i_clk_en && (r_busy_cnt != '0)) begin
      r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
    end
  end

  assign w_busy = (r_busy_cnt != '0);
`else
  // Busy feature not built; keep the parameters referenced so the build stays warning-free
  logic [BUSY_W-1:0] w_unused_busy_cfg;
  assign w_unused_busy_cfg = BUSY_W'(BUSY_CYCLES);
  assign w_busy            = 1'b0;
`endif

  assign o_value_A      = r_value_A;
  assign o_value_B      = r_value_B;
  assign o_load_A       = r_load_A;
  assign o_load_B       = r_load_B;
  assign o_enable_irq_A = r_enable_irq_A;
  assign o_enable_irq_B = r_enable_irq_B;
  assign o_ch3_mode     = r_ch3_mode;
  assign o_clr_flag_A   = r_clr_flag_A;
  assign o_clr_flag_B   = r_clr_flag_B;
  assign o_csm_keyon    = r_csm_keyon;

  // Status byte read path is combinational from busy and the live timer flags
  assign o_dout = {w_busy, 5'b00000, i_flag_B, i_flag_A};

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// Testbench for jt12_timer_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a register-map reference model.
module tb_jt12_timer_ctrl;

  localparam int BC = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       wr = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic       ovf = 1'b0;

  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, clr_A, clr_B, irq_A, irq_B, csm;
  logic [1:0] ch3;
  logic [7:0] dout;

  int n_total = 0;
  int n_bad   = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  jt12_timer_ctrl #(.BUSY_CYCLES(BC), .BUSY_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_wr(wr), .i_addr(addr),
    .i_din(din), .i_flag_A(flag_A), .i_flag_B(flag_B), .i_overflow_A(ovf),
    .o_value_A(value_A), .o_value_B(value_B), .o_load_A(load_A), .o_load_B(load_B),
    .o_clr_flag_A(clr_A), .o_clr_flag_B(clr_B), .o_enable_irq_A(irq_A),
    .o_enable_irq_B(irq_B), .o_ch3_mode(ch3), .o_csm_keyon(csm), .o_dout(dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: byte register map + tick bookkeeping ----------
  logic [7:0] m_sel;
  logic [7:0] m_map [4];   // 0x24..0x27 as written (ctrl stored without bits 5:4)
  logic       m_clrA, m_clrB, m_csm;
  int         m_ticks, m_last;
  bit         m_wrote;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel <= 8'h00;
      for (int i = 0; i < 4; i++) m_map[i] <= 8'h00;
      m_clrA <= 1'b0; m_clrB <= 1'b0; m_csm <= 1'b0;
      m_ticks <= 0; m_last <= 0; m_wrote <= 1'b0;
    end else begin
      m_clrA <= 1'b0;
      m_clrB <= 1'b0;
      if (wr && !addr) m_sel <= din;
      if (wr && addr) begin
        if (m_sel >= 8'h24 && m_sel <= 8'h27)
          m_map[m_sel[1:0]] <= (m_sel == 8'h27) ? (din & 8'hCF) : din;
        if (m_sel == 8'h27) begin
          m_clrA <= din[4];
          m_clrB <= din[5];
        end
        // busy lasts BC clk_en ticks counted after the write edge
        m_last  <= m_ticks + (clk_en ? 1 : 0);
        m_wrote <= 1'b1;
      end
      if (clk_en) m_ticks <= m_ticks + 1;
      m_csm <= clk_en & ovf & m_map[3][7];
    end
  end

  function automatic logic exp_busy();
`ifdef JT12_TIMER_BUSY_EN
    return m_wrote && ((m_ticks - m_last) < BC);
`else
    return 1'b0;
`endif
  endfunction

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_value_A", value_A, {m_map[0], m_map[1][1:0]});
      chk("m_value_B", value_B, m_map[2]);
      chk("m_load_A",  load_A,  m_map[3][0]);
      chk("m_load_B",  load_B,  m_map[3][1]);
      chk("m_irq_A",   irq_A,   m_map[3][2]);
      chk("m_irq_B",   irq_B,   m_map[3][3]);
      chk("m_ch3",     ch3,     m_map[3][7:6]);
      chk("m_clr_A",   clr_A,   m_clrA);
      chk("m_clr_B",   clr_B,   m_clrB);
      chk("m_csm",     csm,     m_csm);
      chk("m_dout",    dout,    {exp_busy(), 5'b00000, flag_B, flag_A});
    end
  end

  // ---------------- stimulus helpers (inputs change 2 time units after posedge) ----
  task automatic step(input logic w, input logic a, input logic [7:0] d,
                      input logic ce, input logic ov);
    wr = w; addr = a; din = d; clk_en = ce; ovf = ov;
    @(posedge clk); #2;
    wr = 1'b0; addr = 1'b0; clk_en = 1'b0; ovf = 1'b0;
  endtask

  task automatic wreg(input logic [7:0] r, input logic [7:0] d);
    step(1'b1, 1'b0, r, 1'b0, 1'b0);
    step(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  // counts clk_en ticks (every 4th clk) seen while busy, stopping when busy drops or at stop_at
  task automatic count_busy(input int stop_at, output int ticks);
    int n;
    ticks = 0;
    n = 0;
    while (dout[7] && ticks < stop_at && n < 400) begin
      if (n % 4 == 3) ticks++;
      step(1'b0, 1'b0, 8'h00, (n % 4 == 3), 1'b0);
      n++;
    end
    if (n >= 400) chk("busy_timeout", n, 0);
  endtask

  int t1, t2, t3;
  int exp_ticks;

  initial begin
`ifdef JT12_TIMER_BUSY_EN
    exp_ticks = BC;
`else
    exp_ticks = 0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // reset state
    chk("rst_value_A", value_A, 0);
    chk("rst_value_B", value_B, 0);
    chk("rst_ctrl", {ch3, irq_B, irq_A, load_B, load_A}, 0);
    chk("rst_pulses", {clr_B, clr_A, csm}, 0);
    chk("rst_dout", dout, 0);

    // Timer A reload value across two registers
    wreg(8'h24, 8'hFF);
    chk("na_hi", value_A, 10'h3FC);
    wreg(8'h25, 8'h03);
    chk("na_full", value_A, 10'h3FF);
    chk("na_others", {value_B, load_A, load_B, ch3}, 0);

    // control write with clear-A
    wreg(8'h27, 8'h15);
    chk("ctl_load_A", load_A, 1);
    chk("ctl_irq_A", irq_A, 1);
    chk("ctl_load_B", load_B, 0);
    chk("ctl_clr_A_on", clr_A, 1);
    chk("ctl_clr_B_on", clr_B, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ctl_clr_A_off", clr_A, 0);
    chk("ctl_clr_B_off", clr_B, 0);

    // CSM strobes
    wreg(8'h27, 8'h81);
    chk("csm_mode", ch3, 2'b10);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("csm_on1", csm, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("csm_off1", csm, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("csm_no_clken", csm, 0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("csm_on2", csm, 1);
    wreg(8'h27, 8'h01);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("csm_normal_mode", csm, 0);

    // busy: drain, single write, then an extending write at tick 10
    for (int i = 0; i < 200 && dout[7]; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("busy_drained", dout[7], 0);
    wreg(8'h26, 8'h5A);
    count_busy(1000, t1);
    chk("busy_single_ticks", t1, exp_ticks);
    chk("busy_single_end", dout[7], 0);
    wreg(8'h26, 8'h11);
    count_busy(10, t2);
    wreg(8'h26, 8'h22);
    chk("busy_reload_val", value_B, 8'h22);
    count_busy(1000, t3);
    chk("busy_extended_ticks", t3, exp_ticks);

    // clear commands coincide with overflow and a rising flag
    wreg(8'h27, 8'h81);
    step(1'b1, 1'b0, 8'h27, 1'b0, 1'b0);
    flag_A = 1'b1;
    step(1'b1, 1'b1, 8'h30, 1'b1, 1'b1);
    chk("co_clr_A", clr_A, 1);
    chk("co_clr_B", clr_B, 1);
    chk("co_csm_old_mode", csm, 1);
    chk("co_mode", ch3, 0);
    chk("co_flags", dout[1:0], 2'b01);
    flag_B = 1'b1;
    #1 chk("co_flags_B", dout[1:0], 2'b11);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("co_pulses_off", {clr_A, clr_B, csm}, 0);
    flag_A = 1'b0;
    flag_B = 1'b0;

    // asynchronous reset in the middle of a clear pulse and busy window
    wreg(8'h27, 8'h13);
    chk("ar_pulse_pending", clr_A, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_value_A", value_A, 0);
    chk("ar_ctrl", {ch3, irq_B, irq_A, load_B, load_A}, 0);
    chk("ar_pulses", {clr_B, clr_A, csm}, 0);
    chk("ar_dout", dout, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic w, a, ce, ov;
      logic [7:0] d;
      w  = 1'($urandom_range(0, 1));
      a  = 1'($urandom_range(0, 1));
      d  = a ? 8'($urandom) : 8'($urandom_range(8'h22, 8'h28));
      ce = ($urandom_range(0, 2) == 0);
      ov = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) flag_A = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) flag_B = 1'($urandom_range(0, 1));
      step(w, a, d, ce, ov);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
